// File: rtl/tdc_pkg.sv
// tdc_pkg
//   Shared types and default parameter values for the TDC count unwrapper.
//   tdc_state_e : controller states (IDLE, PRIME, RUN).
//   *_DEF       : default values for the tdc_count_unwrapper parameters.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tdc_state_e;

    localparam int CNT_W_DEF     = 7;
    localparam int ACC_W_DEF     = 24;
    localparam int AVG_LOG2_DEF  = 2;
    localparam int MAX_DELTA_DEF = 100;
    localparam int ERR_LIMIT_DEF = 3;

endpackage

// File: rtl/tdc_window_sum.sv
// tdc_window_sum
//   Sums 2^AVG_LOG2 accepted deltas and publishes the total once per window.
//   clk       in  : reference clock (rising edge)
//   rst       in  : asynchronous active-high reset
//   clr       in  : discard the partial window (takes priority over add_en)
//   add_en    in  : add delta into the running window this cycle
//   delta     in  : W-bit increment to accumulate
//   sum       out : total of the last completed window
//   sum_valid out : one-cycle pulse, sum was updated
module tdc_window_sum #(
    parameter int W        = 7,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic [W-1:0]          delta,
    output logic [W+AVG_LOG2-1:0] sum,
    output logic                  sum_valid
);

    localparam int SW = W + AVG_LOG2;
    // A one-sample window still needs a 1-bit counter to keep widths legal.
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << AVG_LOG2) - 1);

    logic [SW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] acc_plus;

    // 2^AVG_LOG2 deltas of W bits each fit in SW bits, so no overflow.
    assign acc_plus = acc_q + {{AVG_LOG2{1'b0}}, delta};

    // NOTE: clocked state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (add_en) begin
                if (cnt_q == LAST_IDX) begin
                    sum       <= acc_plus;
                    sum_valid <= 1'b1;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end else begin
                    acc_q <= acc_plus;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tdc_count_unwrapper.sv
// tdc_count_unwrapper
//   Turns wrapped TDC ripple-counter samples into an unwrapped phase, a
//   per-cycle increment and a windowed frequency sum, rejecting implausible
//   increments and re-priming after ERR_LIMIT consecutive rejects.
//   clk         in  : reference clock (rising edge)
//   rst         in  : asynchronous active-high reset
//   en          in  : block enable; low forces IDLE
//   count_valid in  : count_in carries a fresh sample
//   count_in    in  : wrapped CNT_W-bit DCO edge count
//   phase_out   out : unwrapped ACC_W-bit phase
//   phase_valid out : pulse, phase_out/delta_out updated
//   delta_out   out : increment applied at the last update
//   freq_sum    out : sum of the last completed window of deltas
//   sum_valid   out : pulse, freq_sum updated
//   glitch      out : pulse, current sample rejected
//   resync      out : pulse, reject limit reached, back to PRIME
module tdc_count_unwrapper
    import tdc_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int AVG_LOG2  = AVG_LOG2_DEF,
    parameter int MAX_DELTA = MAX_DELTA_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      count_valid,
    input  logic [CNT_W-1:0]          count_in,
    output logic [ACC_W-1:0]          phase_out,
    output logic                      phase_valid,
    output logic [CNT_W-1:0]          delta_out,
    output logic [CNT_W+AVG_LOG2-1:0] freq_sum,
    output logic                      sum_valid,
    output logic                      glitch,
    output logic                      resync
);

    localparam int GW = $clog2(ERR_LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX_DELTA_C = CNT_W'(MAX_DELTA);
    localparam logic [GW-1:0]    ERR_LIMIT_C = GW'(ERR_LIMIT);

    tdc_state_e       state_q, state_d;
    logic [CNT_W-1:0] last_count_q, last_count_d;
    logic [CNT_W-1:0] last_delta_q, last_delta_d;
    logic [GW-1:0]    gcnt_q, gcnt_d, gcnt_inc;
    logic [ACC_W-1:0] phase_d;
    logic [CNT_W-1:0] delta_out_d;
    logic             phase_valid_d, glitch_d, resync_d;

    logic [CNT_W-1:0] raw;
    logic [CNT_W-1:0] delta;
    logic             win_clr, win_add;

    // Modular difference: CNT_W-bit subtraction wraps exactly like the counter.
    assign raw      = count_in - last_count_q;
    assign gcnt_inc = gcnt_q + 1'b1;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        last_count_d  = last_count_q;
        last_delta_d  = last_delta_q;
        gcnt_d        = gcnt_q;
        phase_d       = phase_out;
        delta_out_d   = delta_out;
        phase_valid_d = 1'b0;
        glitch_d      = 1'b0;
        resync_d      = 1'b0;
        delta         = raw;
        win_clr       = 1'b0;
        win_add       = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    win_clr = 1'b1;
                end
                PRIME: begin
                    if (count_valid) begin
                        last_count_d = count_in;
                        last_delta_d = '0;
                        win_clr      = 1'b1;
                        state_d      = RUN;
                    end
                end
                RUN: begin
                    if (count_valid) begin
                        if (raw <= MAX_DELTA_C) begin
                            delta        = raw;
                            last_count_d = count_in;
                            gcnt_d       = '0;
                        end else begin
                            // Reuse the last good increment and extrapolate the
                            // reference count so the next sample lines up.
                            delta        = last_delta_q;
                            last_count_d = last_count_q + last_delta_q;
                            glitch_d     = 1'b1;
                            gcnt_d       = gcnt_inc;
                        end

                        if (glitch_d && gcnt_inc == ERR_LIMIT_C) begin
                            resync_d = 1'b1;
                            gcnt_d   = '0;
                            win_clr  = 1'b1;
                            state_d  = PRIME;
                        end else begin
                            phase_d       = phase_out + {{(ACC_W-CNT_W){1'b0}}, delta};
                            delta_out_d   = delta;
                            last_delta_d  = delta;
                            phase_valid_d = 1'b1;
                            win_add       = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_count_q <= '0;
            last_delta_q <= '0;
            gcnt_q       <= '0;
            phase_out    <= '0;
            delta_out    <= '0;
            phase_valid  <= 1'b0;
            glitch       <= 1'b0;
            resync       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_count_q <= last_count_d;
            last_delta_q <= last_delta_d;
            gcnt_q       <= gcnt_d;
            phase_out    <= phase_d;
            delta_out    <= delta_out_d;
            phase_valid  <= phase_valid_d;
            glitch       <= glitch_d;
            resync       <= resync_d;
        end
    end

    tdc_window_sum #(
        .W        (CNT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_window_sum (
        .clk       (clk),
        .rst       (rst),
        .clr       (win_clr),
        .add_en    (win_add),
        .delta     (delta),
        .sum       (freq_sum),
        .sum_valid (sum_valid)
    );

endmodule

// File: tb/tb_tdc_count_unwrapper.sv
// tb_tdc_count_unwrapper
//   Directed scenarios with literal expectations, then randomized samples,
//   all compared every cycle against a behavioural model of the unwrapper.
module tb_tdc_count_unwrapper;

    localparam int CNT_W     = 7;
    localparam int ACC_W     = 24;
    localparam int AVG_LOG2  = 2;
    localparam int MAX_DELTA = 100;
    localparam int ERR_LIMIT = 3;
    localparam int MOD_CNT   = 1 << CNT_W;
    localparam longint MOD_ACC = longint'(1) << ACC_W;
    localparam int WIN_LEN   = 1 << AVG_LOG2;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      en = 1'b0;
    logic                      count_valid = 1'b0;
    logic [CNT_W-1:0]          count_in = '0;
    logic [ACC_W-1:0]          phase_out;
    logic                      phase_valid;
    logic [CNT_W-1:0]          delta_out;
    logic [CNT_W+AVG_LOG2-1:0] freq_sum;
    logic                      sum_valid;
    logic                      glitch;
    logic                      resync;

    int total = 0;
    int bad   = 0;

    tdc_count_unwrapper #(
        .CNT_W(CNT_W), .ACC_W(ACC_W), .AVG_LOG2(AVG_LOG2),
        .MAX_DELTA(MAX_DELTA), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .count_valid(count_valid),
        .count_in(count_in), .phase_out(phase_out), .phase_valid(phase_valid),
        .delta_out(delta_out), .freq_sum(freq_sum), .sum_valid(sum_valid),
        .glitch(glitch), .resync(resync)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int     m_mode;
    int     m_last_count, m_last_delta, m_errs;
    longint m_phase;
    int     m_delta, m_freq;
    bit     m_pv, m_sv, m_gl, m_rs;
    int     m_win[$];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_last_count = 0; m_last_delta = 0; m_errs = 0;
        m_phase = 0; m_delta = 0; m_freq = 0;
        m_pv = 0; m_sv = 0; m_gl = 0; m_rs = 0;
        m_win.delete();
    endtask

    task automatic model_step(input bit e, input bit v, input int c);
        int raw, d, s;
        bit bad_sample;
        m_pv = 0; m_sv = 0; m_gl = 0; m_rs = 0;
        if (!e) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_PRIME;
            m_win.delete();
        end else if (m_mode == M_PRIME) begin
            if (v) begin
                m_last_count = c;
                m_last_delta = 0;
                m_win.delete();
                m_mode = M_RUN;
            end
        end else if (v) begin
            raw = (c - m_last_count + MOD_CNT) % MOD_CNT;
            bad_sample = (raw > MAX_DELTA);
            if (!bad_sample) begin
                d = raw;
                m_last_count = c;
                m_errs = 0;
            end else begin
                d = m_last_delta;
                m_last_count = (m_last_count + m_last_delta) % MOD_CNT;
                m_gl = 1;
                m_errs++;
            end
            if (m_errs == ERR_LIMIT) begin
                m_rs = 1;
                m_errs = 0;
                m_win.delete();
                m_mode = M_PRIME;
            end else begin
                m_phase = (m_phase + d) % MOD_ACC;
                m_delta = d;
                m_last_delta = d;
                m_pv = 1;
                m_win.push_back(d);
                if (m_win.size() == WIN_LEN) begin
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    m_freq = s;
                    m_sv = 1;
                    m_win.delete();
                end
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model advances on each edge; DUT compared 2 time units later.
    always @(posedge clk) begin
        if (!rst) model_step(en, count_valid, int'(count_in));
        #2;
        check("phase_out",   longint'(phase_out),   m_phase);
        check("delta_out",   longint'(delta_out),   longint'(m_delta));
        check("freq_sum",    longint'(freq_sum),    longint'(m_freq));
        check("phase_valid", longint'(phase_valid), longint'(m_pv));
        check("sum_valid",   longint'(sum_valid),   longint'(m_sv));
        check("glitch",      longint'(glitch),      longint'(m_gl));
        check("resync",      longint'(resync),      longint'(m_rs));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit e, input bit v, input int c);
        @(negedge clk);
        en = e; count_valid = v; count_in = CNT_W'(c);
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; count_valid = 1'b0; count_in = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, enter PRIME, and prime with value p.
    task automatic start_at(input int p);
        do_reset();
        cyc(1, 0, 0);
        cyc(1, 1, p);
    endtask

    initial begin
        int base, r, v;
        model_reset();
        rst = 1'b1;
        #12;
        check("rst_phase", longint'(phase_out), 0);
        check("rst_valid", longint'(phase_valid), 0);
        rst = 1'b0;

        // Basic unwrap: 10 primes, 20 and 30 each add 10.
        start_at(10);
        check("prime_no_pulse", longint'(phase_valid), 0);
        cyc(1, 1, 20);
        check("basic_phase1", longint'(phase_out), 10);
        check("basic_delta1", longint'(delta_out), 10);
        check("basic_pv1",    longint'(phase_valid), 1);
        cyc(1, 1, 30);
        check("basic_phase2", longint'(phase_out), 20);

        // Count wrap: 120 -> 125 -> 3.
        start_at(120);
        cyc(1, 1, 125);
        check("wrap_delta1", longint'(delta_out), 5);
        check("wrap_phase1", longint'(phase_out), 5);
        cyc(1, 1, 3);
        check("wrap_delta2", longint'(delta_out), 6);
        check("wrap_phase2", longint'(phase_out), 11);
        check("wrap_glitch", longint'(glitch), 0);

        // Window sum: deltas 4,5,6,7 -> 22 on the fourth update.
        start_at(0);
        cyc(1, 1, 4);
        cyc(1, 1, 9);
        cyc(1, 1, 15);
        check("win_early_sv", longint'(sum_valid), 0);
        cyc(1, 1, 22);
        check("win_sum",   longint'(freq_sum), 22);
        check("win_sv",    longint'(sum_valid), 1);
        check("win_pv",    longint'(phase_valid), 1);

        // Single glitch, then recovery.
        start_at(0);
        cyc(1, 1, 10);
        cyc(1, 1, 120);
        check("gl_flag",  longint'(glitch), 1);
        check("gl_delta", longint'(delta_out), 10);
        check("gl_phase", longint'(phase_out), 20);
        cyc(1, 1, 30);
        check("gl_recover_delta", longint'(delta_out), 10);
        check("gl_recover_glitch", longint'(glitch), 0);

        // Resync after three rejects (last_count 30 -> 40 -> 50).
        cyc(1, 1, 12);
        check("rs1_glitch", longint'(glitch), 1);
        check("rs1_pv",     longint'(phase_valid), 1);
        cyc(1, 1, 22);
        check("rs2_glitch", longint'(glitch), 1);
        check("rs2_phase",  longint'(phase_out), 50);
        cyc(1, 1, 32);
        check("rs3_glitch", longint'(glitch), 1);
        check("rs3_resync", longint'(resync), 1);
        check("rs3_pv",     longint'(phase_valid), 0);
        check("rs3_phase",  longint'(phase_out), 50);
        cyc(1, 1, 50);
        check("reprime_pv", longint'(phase_valid), 0);
        cyc(1, 1, 57);
        check("reprime_delta", longint'(delta_out), 7);
        check("reprime_phase", longint'(phase_out), 57);

        // en low with a sample: ignored, outputs hold.
        cyc(0, 1, 70);
        check("en_off_pv",    longint'(phase_valid), 0);
        check("en_off_phase", longint'(phase_out), 57);

        // Reset mid-window clears outputs before the next edge.
        cyc(1, 0, 0);
        cyc(1, 1, 70);
        cyc(1, 1, 75);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_phase", longint'(phase_out), 0);
        check("arst_delta", longint'(delta_out), 0);
        check("arst_freq",  longint'(freq_sum), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        base = 0;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)        v = $urandom_range(0, MOD_CNT - 1);
            else if (r < 11)  begin base = (base + MAX_DELTA) % MOD_CNT; v = base; end
            else if (r < 13)  begin base = (base + MAX_DELTA + 1) % MOD_CNT; v = base; end
            else              begin base = (base + $urandom_range(0, 25)) % MOD_CNT; v = base; end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 75, v);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
